// File: rtl/ramb_port_arbiter.sv
// ramb_port_arbiter: owns port B of the shared dual-port block RAM and
// arbitrates it between the ADC sample writer and the VGA pixel reader.
// VGA has priority; a starvation counter forces an ADC grant after
// STARVE_LIMIT consecutive VGA grants while a sample is pending.
// ADC samples fill a circular capture buffer at BUF_BASE..BUF_BASE+BUF_LEN-1.
//
// Optional feature: define RAMB_ARB_FREEZE_EN to add the `freeze` input,
// which blocks ADC writes so the CPU can read a stable capture buffer.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ram_wEn/addr/dataIn   RAM port B controls
//   ram_dataOut           RAM port B registered read data
//   adc_valid/data/ready  ADC sample handshake
//   vga_req/addr/gnt      VGA read request and grant
//   vga_rdata/rvalid      VGA read data, valid one cycle after grant
//   wr_ptr                next write offset within the capture buffer
//   buf_wrap              one-cycle pulse after the write at BUF_LEN-1
//   freeze                (RAMB_ARB_FREEZE_EN only) hold off ADC writes
module ramb_port_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned BUF_BASE      = 'h800,
  parameter int unsigned BUF_LEN       = 1024,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef RAMB_ARB_FREEZE_EN
  input  logic                     freeze,
`endif
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut,
  input  logic                     adc_valid,
  input  logic [DATA_WIDTH-1:0]    adc_data,
  output logic                     adc_ready,
  input  logic                     vga_req,
  input  logic [ADDRESS_WIDTH-1:0] vga_addr,
  output logic                     vga_gnt,
  output logic [DATA_WIDTH-1:0]    vga_rdata,
  output logic                     vga_rvalid,
  output logic [ADDRESS_WIDTH-1:0] wr_ptr,
  output logic                     buf_wrap
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] BASE_A   = ADDRESS_WIDTH'(BUF_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_OFF = ADDRESS_WIDTH'(BUF_LEN - 1);
  localparam logic [SW-1:0]            LIMIT    = SW'(STARVE_LIMIT);

  logic [SW-1:0]            starve_cnt;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q;
  logic                     rvalid_q;
  logic                     wrap_q;

  logic                     frz;
  logic                     adc_req;
  logic                     force_adc;
  logic                     adc_gnt;
  logic                     vga_gnt_i;
  logic [ADDRESS_WIDTH-1:0] ptr_c;

`ifdef RAMB_ARB_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif

  // Grant decision: frozen ADC looks idle; reset blocks both requesters.
  always_comb begin
    adc_req   = adc_valid && !frz;
    force_adc = adc_req && (starve_cnt == LIMIT);
    adc_gnt   = !reset && adc_req && (force_adc || !vga_req);
    vga_gnt_i = !reset && vga_req && !force_adc;
  end

  // Port B drive; registered state is masked while reset is held so the
  // outputs show their reset values from the first reset cycle.
  always_comb begin
    ptr_c      = reset ? '0 : wr_ptr_q;
    ram_wEn    = adc_gnt;
    adc_ready  = adc_gnt;
    vga_gnt    = vga_gnt_i;
    ram_addr   = BASE_A + ptr_c;
    ram_dataIn = adc_data;
    if (vga_gnt_i) begin
      ram_addr = vga_addr;
    end
    vga_rdata  = ram_dataOut;
    vga_rvalid = rvalid_q && !reset;
    wr_ptr     = ptr_c;
    buf_wrap   = wrap_q && !reset;
  end

  // Write pointer, wrap pulse, read-valid pipe and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      wr_ptr_q   <= '0;
      rvalid_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      rvalid_q <= vga_gnt_i;
      wrap_q   <= 1'b0;
      if (adc_gnt) begin
        if (wr_ptr_q == LAST_OFF) begin
          wr_ptr_q <= '0;
          wrap_q   <= 1'b1;
        end else begin
          wr_ptr_q <= wr_ptr_q + ADDRESS_WIDTH'(1);
        end
      end
      // Counts only VGA wins over a pending sample; anything else clears it.
      if (vga_gnt_i && adc_req) begin
        if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ramb_port_arbiter.sv
// Scoreboard bench for ramb_port_arbiter: stimulus pushes hand-computed
// port B events (write, VGA grant, VGA read data, wrap pulse) into a queue,
// and a negedge monitor pops and compares each event the DUT presents.
// A second instance with BUF_LEN=1 covers the single-word buffer case.
module tb_ramb_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  localparam int K_W   = 0;
  localparam int K_G   = 1;
  localparam int K_R   = 2;
  localparam int K_P   = 3;
  localparam int K_BAD = 4;

  typedef struct {
    int          kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
`ifdef RAMB_ARB_FREEZE_EN
  logic          freeze;
`endif
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          adc_ready;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic [AW-1:0] wr_ptr;
  logic          buf_wrap;

  logic          d1_wen;
  logic [AW-1:0] d1_addr;
  logic [DW-1:0] d1_din;
  logic          d1_ready;
  logic          d1_gnt;
  logic [DW-1:0] d1_rdata;
  logic          d1_rvalid;
  logic [AW-1:0] d1_ptr;
  logic          d1_wrap;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  ev_t           exp_q [$];
  int            checks   = 0;
  int            failures = 0;
  logic          pend_r   = 1'b0;
  logic [DW-1:0] pend_rd  = '0;

  always #5 clk = ~clk;

  ramb_port_arbiter #(.BUF_LEN(8), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .reset(reset),
`ifdef RAMB_ARB_FREEZE_EN
    .freeze(freeze),
`endif
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn),
    .ram_dataOut(ram_dataOut),
    .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(adc_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .wr_ptr(wr_ptr), .buf_wrap(buf_wrap)
  );

  ramb_port_arbiter #(.BUF_LEN(1), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset),
`ifdef RAMB_ARB_FREEZE_EN
    .freeze(freeze),
`endif
    .ram_wEn(d1_wen), .ram_addr(d1_addr), .ram_dataIn(d1_din),
    .ram_dataOut(32'h0),
    .adc_valid(adc_valid), .adc_data(adc_data), .adc_ready(d1_ready),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(d1_gnt),
    .vga_rdata(d1_rdata), .vga_rvalid(d1_rvalid),
    .wr_ptr(d1_ptr), .buf_wrap(d1_wrap)
  );

  // Block RAM port B model: write plus read-first registered read.
  always @(posedge clk) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  function automatic void push(input int kind, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input string nm, input int kind,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got kind=%0d addr=%h data=%h, required no event",
               nm, kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.data !== d) begin
        failures++;
        $display("FAIL %s: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 nm, kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Monitor: every event the DUT shows is matched against the queue head.
  always @(negedge clk) begin
    if (ram_wEn || adc_ready)
      expect_ev("write", (ram_wEn && adc_ready) ? K_W : K_BAD, ram_addr, ram_dataIn);
    if (vga_gnt)    expect_ev("vga_gnt", K_G, ram_addr, '0);
    if (vga_rvalid) expect_ev("vga_rdata", K_R, '0, vga_rdata);
    if (buf_wrap)   expect_ev("buf_wrap", K_P, '0, '0);
  end

  // One clock cycle of stimulus plus the events required during it.
  task automatic cyc(input logic rst, input logic av, input logic [DW-1:0] ad,
                     input logic vr, input logic [AW-1:0] va,
                     input logic ew, input logic [AW-1:0] ewa,
                     input logic eg, input logic [DW-1:0] erd, input logic ep);
    @(posedge clk);
    #1;
    reset     = rst;
    adc_valid = av;
    adc_data  = ad;
    vga_req   = vr;
    vga_addr  = va;
    if (ew) push(K_W, ewa, ad);
    if (eg) push(K_G, va, '0);
    if (pend_r && !rst) push(K_R, '0, pend_rd);
    if (ep) push(K_P, '0, '0);
    pend_r  = eg;
    pend_rd = erd;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  // ADC and VGA both requesting; pat bit k set means cycle k is an ADC grant.
  task automatic contend(input int n, input logic [15:0] pat,
                         input logic [AW-1:0] wa0, input logic [DW-1:0] d0);
    logic [AW-1:0] wa;
    wa = wa0;
    for (int k = 0; k < n; k++) begin
      if (pat[k]) begin
        cyc(1'b0, 1'b1, d0 + DW'(k), 1'b1, 12'h020, 1'b1, wa, 1'b0, '0, 1'b0);
        wa = wa + AW'(1);
      end else begin
        cyc(1'b0, 1'b1, d0 + DW'(k), 1'b1, 12'h020, 1'b0, '0, 1'b1, 32'h11112222, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'h11112222;
    reset     = 1'b1;
    adc_valid = 1'b0;
    adc_data  = '0;
    vga_req   = 1'b0;
    vga_addr  = '0;
`ifdef RAMB_ARB_FREEZE_EN
    freeze    = 1'b0;
`endif

    // Reset state.
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk); #1;
    chk("reset ram_wEn", DW'(ram_wEn), 32'h0);
    chk("reset ram_addr", DW'(ram_addr), 32'h800);
    chk("reset vga_rvalid", DW'(vga_rvalid), 32'h0);
    chk("reset wr_ptr", DW'(wr_ptr), 32'h0);
    chk("reset buf_wrap", DW'(buf_wrap), 32'h0);

    // Three back-to-back ADC writes.
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 32'hA5A50000 + DW'(i), 1'b0, '0, 1'b1, 12'h800 + AW'(i), 1'b0, '0, 1'b0);
    idle();
    @(negedge clk); #1;
    chk("wr_ptr after 3 writes", DW'(wr_ptr), 32'h3);
    chk("buf_wrap after 3 writes", DW'(buf_wrap), 32'h0);

    // Single VGA read.
    cyc(1'b0, 1'b0, '0, 1'b1, 12'h010, 1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    idle();

    // Contention: V,V,V,V,A,V,V,V,V,A; writes land at offsets 3 and 4.
    contend(10, 16'h0210, 12'h803, 32'hC0DE0000);
    idle();
    @(negedge clk); #1;
    chk("wr_ptr after contention", DW'(wr_ptr), 32'h5);

    // Wrap of the 8-word buffer, with the BUF_LEN=1 instance alongside.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 32'hBEEF0000 + DW'(i), 1'b0, '0, 1'b1,
          (i == 3) ? 12'h800 : 12'h805 + AW'(i), 1'b0, '0, (i == 3));
      @(negedge clk); #1;
      chk("len1 ram_wEn", DW'(d1_wen), 32'h1);
      chk("len1 ram_addr", DW'(d1_addr), 32'h800);
      chk("len1 wr_ptr", DW'(d1_ptr), 32'h0);
      chk("len1 buf_wrap", DW'(d1_wrap), (i == 0) ? 32'h0 : 32'h1);
    end
    idle();
    @(negedge clk); #1;
    chk("wr_ptr after wrap", DW'(wr_ptr), 32'h1);
    chk("buf_wrap one cycle", DW'(buf_wrap), 32'h0);
    chk("len1 buf_wrap last", DW'(d1_wrap), 32'h1);
    chk("len1 no vga activity", DW'({d1_ready, d1_gnt, d1_rvalid}), 32'h0);
    chk("len1 rdata passthrough", d1_rdata, 32'h0);
    chk("len1 dataIn passthrough", d1_din, 32'h0);

    // Reach wr_ptr=7, VGA grant with ADC pending, then reset.
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, 32'h50000000 + DW'(i), 1'b0, '0, 1'b1, 12'h801 + AW'(i), 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 32'h5000AAAA, 1'b1, 12'h010, 1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk); #1;
    chk("wr_ptr before reset", DW'(wr_ptr), 32'h7);
    cyc(1'b1, 1'b1, 32'h5000AAAA, 1'b1, 12'h010, 1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk); #1;
    chk("reset drops rvalid", DW'(vga_rvalid), 32'h0);
    chk("reset wr_ptr", DW'(wr_ptr), 32'h0);
    chk("reset grants", DW'({ram_wEn, adc_ready, vga_gnt}), 32'h0);
    chk("reset ram_addr base", DW'(ram_addr), 32'h800);
    // Cleared starvation count: four VGA grants before the first write at 0x800.
    contend(5, 16'h0010, 12'h800, 32'h77770000);
    idle();
    @(negedge clk); #1;
    chk("wr_ptr after post-reset write", DW'(wr_ptr), 32'h1);

`ifdef RAMB_ARB_FREEZE_EN
    // Freeze blocks ADC writes; release writes on the same cycle.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      freeze = 1'b1;
      cyc_frozen(i);
    end
    @(posedge clk); #1;
    freeze = 1'b0;
    reset = 1'b0; adc_valid = 1'b1; adc_data = 32'h99990005; vga_req = 1'b0;
    push(K_W, 12'h801, 32'h99990005);
    @(negedge clk); #1;
    chk("unfreeze write", DW'(adc_ready), 32'h1);
    idle();
    @(negedge clk); #1;
    chk("wr_ptr after unfreeze", DW'(wr_ptr), 32'h2);
`endif

    idle();
    idle();
    @(negedge clk); #1;
    chk("scoreboard drained", DW'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

`ifdef RAMB_ARB_FREEZE_EN
  // One frozen cycle with a sample pending; nothing may be written.
  task automatic cyc_frozen(input int i);
    adc_valid = 1'b1;
    adc_data  = 32'h99990000 + DW'(i);
    vga_req   = 1'b0;
    @(negedge clk); #1;
    chk("freeze adc_ready", DW'(adc_ready), 32'h0);
    chk("freeze wr_ptr", DW'(wr_ptr), 32'h1);
  endtask
`endif

endmodule
